repetition_task: RTL

- Processing task that sits directly downstream of an input socket (FIFO wrapper) and directly upstream of an output socket.
- Pops one word at a time from the input socket and pushes REP identical copies of it into the output socket. This is the hardware counterpart of a repetition encoder.
- Tracks frame boundaries of FRAME_LEN input words and flags the last output word of each frame.
- Stalls on upstream empty or downstream full. It never drops or duplicates data beyond REP copies.

---
 rtl/hw_aff3ct_pkg.sv | 17 +
 rtl/repetition_task.sv | 100 ++++++++++
 2 files changed

// File: rtl/hw_aff3ct_pkg.sv
// Shared types and constants for the repetition processing task.
package hw_aff3ct_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EMIT = 2'd2
    } rep_state_t;

    // Counter width that stays at least one bit for degenerate counts of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/repetition_task.sv
// Repetition encoder between two sockets: pops one word, pushes REP copies,
// and marks the final copy of the final word of each FRAME_LEN-word frame.
module repetition_task
    import hw_aff3ct_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int REP        = 3,
    parameter int FRAME_LEN  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_dv,
    input  logic                  i_empty,
    output logic                  o_rd_en,
    input  logic                  i_full,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_wr_en,
    output logic                  o_last,
    output logic                  o_busy
);

    // state  | meaning
    // S_IDLE | waiting for upstream data; issues the read strobe
    // S_WAIT | read issued, capturing the word when i_dv arrives
    // S_EMIT | writing REP copies of hold_q, stalling on i_full

    localparam int RW = cnt_width(REP);
    localparam int FW = cnt_width(FRAME_LEN);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP - 1);
    localparam logic [FW-1:0] WORD_LAST = FW'(FRAME_LEN - 1);

    rep_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [RW-1:0]         rep_cnt_q, rep_cnt_d;
    logic [FW-1:0]         word_idx_q, word_idx_d;
    logic                  rd_en;
    logic                  wr_en;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        rep_cnt_d  = rep_cnt_q;
        word_idx_d = word_idx_q;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                rd_en = ~i_empty;
                if (!i_empty) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_dv) begin
                    hold_d    = i_data;
                    rep_cnt_d = '0;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                wr_en = ~i_full;
                if (wr_en) begin
                    if (rep_cnt_q == REP_LAST) begin
                        rep_cnt_d  = '0;
                        word_idx_d = (word_idx_q == WORD_LAST) ? '0 : word_idx_q + 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            rep_cnt_q  <= '0;
            word_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            rep_cnt_q  <= rep_cnt_d;
            word_idx_q <= word_idx_d;
        end
    end

    // Strobes are masked during reset so nothing moves on the reset cycle itself.
    assign o_rd_en = rd_en & ~i_rst;
    assign o_wr_en = wr_en & ~i_rst;
    assign o_last  = wr_en & ~i_rst & (rep_cnt_q == REP_LAST) & (word_idx_q == WORD_LAST);
    assign o_busy  = (state_q != S_IDLE) & ~i_rst;
    assign o_data  = ((state_q == S_EMIT) && !i_rst) ? hold_q : '0;

endmodule
